// File: rtl/status_uart_tx_if.sv
// Bundle between the game controllers and the status-line UART transmitter.
// The master drives the game state and send_req; the slave returns tx/busy/msg_done.
interface status_uart_tx_if;
    logic [9:0] score;
    logic [3:0] stage;
    logic [2:0] life;
    logic       gameover;
    logic       send_req;
    logic       tx;
    logic       busy;
    logic       msg_done;

    modport master (
        output score, stage, life, gameover, send_req,
        input  tx, busy, msg_done
    );

    modport slave (
        input  score, stage, life, gameover, send_req,
        output tx, busy, msg_done
    );
endinterface

// File: rtl/status_uart_tx.sv
// Game-status UART transmitter: snapshots score/stage/life/gameover on change or request
// and sends the 13-byte line "S<h> L<d> P<ddd><X|->\r\n" as 8N1, LSB first.
module status_uart_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic            clk,
    input  logic            reset,
    status_uart_tx_if.slave bus
);
    localparam int               CNT_W       = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_PRELAST = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [3:0]       LAST_BYTE   = 4'd12;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CONV  = 3'd1,
        LOAD  = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Byte k of the status line, built from the frozen snapshot and decimal digits.
    function automatic logic [7:0] msg_byte(
        input logic [3:0] k,
        input logic [3:0] stg,
        input logic [2:0] lif,
        input logic       go,
        input logic [3:0] hund,
        input logic [3:0] tens,
        input logic [3:0] ones
    );
        logic [7:0] b;
        case (k)
            4'd0:    b = 8'h53;
            4'd1:    b = (stg < 4'd10) ? (8'h30 + {4'h0, stg}) : (8'h37 + {4'h0, stg});
            4'd2:    b = 8'h20;
            4'd3:    b = 8'h4C;
            4'd4:    b = 8'h30 + {5'h00, lif};
            4'd5:    b = 8'h20;
            4'd6:    b = 8'h50;
            4'd7:    b = 8'h30 + {4'h0, hund};
            4'd8:    b = 8'h30 + {4'h0, tens};
            4'd9:    b = 8'h30 + {4'h0, ones};
            4'd10:   b = go ? 8'h58 : 8'h2D;
            4'd11:   b = 8'h0D;
            4'd12:   b = 8'h0A;
            default: b = 8'h0A;
        endcase
        return b;
    endfunction

    state_t           state_r;
    state_t           state_next_s;
    logic [17:0]      live_s;
    logic [17:0]      last_r;
    logic             change_s;
    logic             trigger_s;
    logic             conv_hund_s;
    logic             conv_tens_s;
    logic             byte_end_s;
    logic             pending_r;
    logic             tx_r;
    logic             busy_r;
    logic             msg_done_r;
    logic [3:0]       stage_r;
    logic [2:0]       life_r;
    logic             go_r;
    logic [9:0]       rem_r;
    logic [3:0]       hund_r;
    logic [3:0]       tens_r;
    logic [3:0]       byte_idx_r;
    logic [3:0]       bit_idx_r;
    logic [CNT_W-1:0] cnt_r;
    logic [7:0]       byte_r;

    assign live_s      = {bus.score, bus.stage, bus.life, bus.gameover};
    assign change_s    = (live_s != last_r);
    assign trigger_s   = change_s | bus.send_req | pending_r;
    assign conv_hund_s = (rem_r >= 10'd100);
    assign conv_tens_s = (rem_r >= 10'd10);
    // Between bytes the LOAD cycle doubles as the last stop-bit cycle, so the gap is zero.
    assign byte_end_s  = (bit_idx_r == 4'd9) &&
                         ((byte_idx_r == LAST_BYTE) ? (cnt_r == CNT_LAST) : (cnt_r == CNT_PRELAST));

    assign bus.tx       = tx_r;
    assign bus.busy     = busy_r;
    assign bus.msg_done = msg_done_r;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state decode.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (trigger_s) state_next_s = CONV;
                else           state_next_s = IDLE;
            end
            CONV: begin
                if (!conv_hund_s && !conv_tens_s) state_next_s = LOAD;
                else                              state_next_s = CONV;
            end
            LOAD: state_next_s = SHIFT;
            SHIFT: begin
                if (!byte_end_s)                    state_next_s = SHIFT;
                else if (byte_idx_r == LAST_BYTE)   state_next_s = DONE;
                else                                state_next_s = LOAD;
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // One-deep trigger memory: any request or change seen outside IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_r <= 1'b0;
        end else begin
            pending_r <= (state_r != IDLE) & (pending_r | change_s | bus.send_req);
        end
    end

    // Snapshot, decimal conversion by repeated subtraction, and bit serialiser.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_r     <= 18'd0;
            stage_r    <= 4'd0;
            life_r     <= 3'd0;
            go_r       <= 1'b0;
            rem_r      <= 10'd0;
            hund_r     <= 4'd0;
            tens_r     <= 4'd0;
            byte_idx_r <= 4'd0;
            bit_idx_r  <= 4'd0;
            cnt_r      <= {CNT_W{1'b0}};
            byte_r     <= 8'd0;
            tx_r       <= 1'b1;
            busy_r     <= 1'b0;
            msg_done_r <= 1'b0;
        end else begin
            msg_done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (trigger_s) begin
                        last_r     <= live_s;
                        stage_r    <= bus.stage;
                        life_r     <= bus.life;
                        go_r       <= bus.gameover;
                        rem_r      <= (bus.score > 10'd999) ? 10'd999 : bus.score;
                        hund_r     <= 4'd0;
                        tens_r     <= 4'd0;
                        byte_idx_r <= 4'd0;
                        busy_r     <= 1'b1;
                    end
                end
                CONV: begin
                    if (conv_hund_s) begin
                        rem_r  <= rem_r - 10'd100;
                        hund_r <= hund_r + 4'd1;
                    end else if (conv_tens_s) begin
                        rem_r  <= rem_r - 10'd10;
                        tens_r <= tens_r + 4'd1;
                    end
                end
                LOAD: begin
                    byte_r    <= msg_byte(byte_idx_r, stage_r, life_r, go_r, hund_r, tens_r, rem_r[3:0]);
                    tx_r      <= 1'b0;
                    bit_idx_r <= 4'd0;
                    cnt_r     <= {CNT_W{1'b0}};
                end
                SHIFT: begin
                    if (byte_end_s) begin
                        byte_idx_r <= byte_idx_r + 4'd1;
                        if (byte_idx_r == LAST_BYTE) begin
                            msg_done_r <= 1'b1;
                            busy_r     <= 1'b0;
                        end
                    end else if (cnt_r == CNT_LAST) begin
                        cnt_r     <= {CNT_W{1'b0}};
                        bit_idx_r <= bit_idx_r + 4'd1;
                        tx_r      <= (bit_idx_r == 4'd8) ? 1'b1 : byte_r[bit_idx_r[2:0]];
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                // A queued trigger is certain to fire next cycle, so busy stays low for DONE only.
                DONE: busy_r <= pending_r | change_s | bus.send_req;
                default: busy_r <= 1'b0;
            endcase
        end
    end
endmodule

// File: tb/tb_status_uart_tx.sv
// Randomized bench for status_uart_tx: a UART line decoder feeds a byte queue that is
// compared with status lines computed from the driven values by plain arithmetic.
module tb_status_uart_tx;
    localparam int CPB = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;

    status_uart_tx_if bus();

    status_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Line decoder and timing observer.
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] rx_byte   = 8'd0;
    logic       tx_prev   = 1'b1;
    logic       in_frame  = 1'b0;
    logic       msg_active = 1'b0;
    logic       gap_track = 1'b0;
    int ph        = 0;
    int fall_cyc  = 0;
    int last_len  = 0;
    int gap_cnt   = 0;
    int last_gap  = -1;
    int done_cnt  = 0;
    int low_cnt   = 0;
    int busy_cnt  = 0;
    int err_cnt   = 0;

    always @(negedge clk) begin
        if (reset) begin
            in_frame   <= 1'b0;
            msg_active <= 1'b0;
            tx_prev    <= 1'b1;
            gap_track  <= 1'b0;
        end else begin
            tx_prev <= bus.tx;
            if (!bus.tx) low_cnt <= low_cnt + 1;
            if (bus.busy) busy_cnt <= busy_cnt + 1;
            if (bus.msg_done) begin
                done_cnt   <= done_cnt + 1;
                last_len   <= msg_active ? (cyc - fall_cyc) : -1;
                msg_active <= 1'b0;
                gap_track  <= 1'b1;
                gap_cnt    <= 1;
                if (bus.busy) err_cnt <= err_cnt + 1;
            end else if (gap_track) begin
                if (bus.busy) begin
                    last_gap  <= gap_cnt;
                    gap_track <= 1'b0;
                end else begin
                    gap_cnt <= gap_cnt + 1;
                end
            end
            if (in_frame) begin
                ph <= ph + 1;
                if ((ph + 1 == CPB / 2) && bus.tx) err_cnt <= err_cnt + 1;
                if ((ph + 1 > CPB) && (ph + 1 < 9 * CPB) && (((ph + 1 - CPB / 2) % CPB) == 0))
                    rx_byte[3'(((ph + 1 - CPB / 2) / CPB) - 1)] <= bus.tx;
                if (ph + 1 == 9 * CPB + CPB / 2) begin
                    if (!bus.tx) err_cnt <= err_cnt + 1;
                    rx_q.push_back(rx_byte);
                    in_frame <= 1'b0;
                end
            end else if (tx_prev && !bus.tx) begin
                in_frame <= 1'b1;
                ph       <= 0;
                if (!msg_active) begin
                    msg_active <= 1'b1;
                    fall_cyc   <= cyc;
                end
            end
        end
    end

    // Reference: the status line for a given set of values.
    task automatic push_line(input int s, input int st, input int l, input int g);
        int v;
        v = (s > 999) ? 999 : s;
        exp_q.push_back("S");
        exp_q.push_back((st < 10) ? 8'(48 + st) : 8'(65 + st - 10));
        exp_q.push_back(" ");
        exp_q.push_back("L");
        exp_q.push_back(8'(48 + l));
        exp_q.push_back(" ");
        exp_q.push_back("P");
        exp_q.push_back(8'(48 + v / 100));
        exp_q.push_back(8'(48 + (v / 10) % 10));
        exp_q.push_back(8'(48 + v % 10));
        exp_q.push_back((g != 0) ? "X" : "-");
        exp_q.push_back(8'd13);
        exp_q.push_back(8'd10);
    endtask

    int trig_cyc  = 0;
    int done_base = 0;

    task automatic drive(input int s, input int st, input int l, input int g, input int r);
        @(posedge clk);
        #1;
        bus.score    = 10'(s);
        bus.stage    = 4'(st);
        bus.life     = 3'(l);
        bus.gameover = 1'(g);
        bus.send_req = 1'(r);
        trig_cyc     = cyc;
        @(posedge clk);
        #1;
        bus.send_req = 1'b0;
    endtask

    task automatic wait_first_fall();
        int t;
        t = 0;
        while (!msg_active && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("first_fall_within_24", 32'((msg_active && (fall_cyc - trig_cyc) <= 24) ? 1 : 0), 32'd1);
    endtask

    task automatic start_msg(input int s, input int st, input int l, input int g, input int r);
        drive(s, st, l, g, r);
        push_line(s, st, l, g);
        @(negedge clk);
        check("busy_after_trigger", 32'(bus.busy), 32'd1);
        wait_first_fall();
    endtask

    task automatic wait_idle();
        int quiet;
        int t;
        quiet = 0;
        t = 0;
        while (quiet < 10 && t < 3000) begin
            @(negedge clk);
            t++;
            if (!bus.busy && !msg_active && !in_frame) quiet++;
            else quiet = 0;
        end
        check("idle_reached", 32'((quiet >= 10) ? 1 : 0), 32'd1);
    endtask

    task automatic finish_case(input int nmsg);
        int n;
        wait_idle();
        check("byte_count", 32'(rx_q.size()), 32'(exp_q.size()));
        n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check($sformatf("byte%0d", i), 32'(rx_q[i]), 32'(exp_q[i]));
        check("msg_done_count", 32'(done_cnt - done_base), 32'(nmsg));
        check("msg_length", 32'(last_len), 32'(130 * CPB));
        check("framing_errors", 32'(err_cnt), 32'd0);
        rx_q.delete();
        exp_q.delete();
        done_base = done_cnt;
    endtask

    int ms, mst, ml, mg;

    initial begin
        int base_low, base_busy, t;
        bus.score = 10'd0; bus.stage = 4'd0; bus.life = 3'd0; bus.gameover = 1'b0; bus.send_req = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_tx", 32'(bus.tx), 32'd1);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_msg_done", 32'(bus.msg_done), 32'd0);

        base_low = low_cnt; base_busy = busy_cnt; done_base = done_cnt;
        repeat (2000) @(negedge clk);
        check("quiet_tx_low_cycles", 32'(low_cnt - base_low), 32'd0);
        check("quiet_busy_cycles", 32'(busy_cnt - base_busy), 32'd0);
        check("quiet_msg_done", 32'(done_cnt - done_base), 32'd0);

        start_msg(123, 3, 5, 0, 0);
        finish_case(1);
        start_msg(1000, 12, 0, 1, 0);
        finish_case(1);

        // Two changes during one message collapse into a single follow-up.
        start_msg(77, 1, 5, 0, 0);
        repeat (100) @(negedge clk);
        drive(77, 1, 4, 0, 0);
        repeat (100) @(negedge clk);
        drive(77, 1, 3, 0, 0);
        push_line(77, 1, 3, 0);
        finish_case(2);
        check("busy_gap_after_change", 32'(last_gap), 32'd1);

        start_msg(77, 1, 3, 0, 1);
        finish_case(1);
        start_msg(77, 1, 3, 0, 1);
        repeat (100) @(negedge clk);
        drive(77, 1, 3, 0, 1);
        repeat (100) @(negedge clk);
        drive(77, 1, 3, 0, 1);
        push_line(77, 1, 3, 0);
        finish_case(2);
        check("busy_gap_after_req", 32'(last_gap), 32'd1);

        // Reset in the middle of byte 6, then the unchanged inputs must be resent.
        start_msg(456, 7, 2, 0, 0);
        t = 0;
        while (rx_q.size() < 6 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check("reached_byte6", 32'((rx_q.size() >= 6) ? 1 : 0), 32'd1);
        repeat (20) @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("midreset_tx", 32'(bus.tx), 32'd1);
        check("midreset_busy", 32'(bus.busy), 32'd0);
        check("midreset_msg_done", 32'(bus.msg_done), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        trig_cyc = cyc;
        check("no_done_for_aborted", 32'(done_cnt - done_base), 32'd0);
        rx_q.delete();
        exp_q.delete();
        done_base = done_cnt;
        push_line(456, 7, 2, 0);
        wait_first_fall();
        finish_case(1);

        ms = 456; mst = 7; ml = 2; mg = 0;
        repeat (6) begin
            int s, st, l, g, r, s2, st2, l2, g2, r2;
            s = $urandom_range(0, 1023); st = $urandom_range(0, 15);
            l = $urandom_range(0, 7);    g = $urandom_range(0, 1);
            r = $urandom_range(0, 1);
            if (s == ms && st == mst && l == ml && g == mg) r = 1;
            start_msg(s, st, l, g, r);
            ms = s; mst = st; ml = l; mg = g;
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(30, 400)) @(negedge clk);
                s2 = $urandom_range(0, 1023); st2 = $urandom_range(0, 15);
                l2 = $urandom_range(0, 7);    g2 = $urandom_range(0, 1);
                r2 = $urandom_range(0, 1);
                if (s2 == ms && st2 == mst && l2 == ml && g2 == mg) r2 = 1;
                drive(s2, st2, l2, g2, r2);
                push_line(s2, st2, l2, g2);
                ms = s2; mst = st2; ml = l2; mg = g2;
                finish_case(2);
                check("busy_gap_random", 32'(last_gap), 32'd1);
            end else begin
                finish_case(1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "time limit");
    end
endmodule

// File: doc/status_uart_tx.md
Name: status_uart_tx

Overview:
- UART transmitter for game status, the return direction of the movement-command UART receiver.
- Watches score, stage, life and gameover from the game controllers.
- On any change, or on an explicit request, it snapshots the values, converts score to decimal and sends a fixed 13-byte ASCII status line, 8N1, LSB first, on the board TX pin.

Parameters:
CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200 baud)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
score  input  10  current score; values above 999 are sent as 999
stage  input  4  current stage index 0..15
life  input  3  current life count 0..7
gameover  input  1  gameover flag
send_req  input  1  one-cycle pulse; forces a message even if nothing changed
tx  output  1  UART serial output; idles high
busy  output  1  high from the snapshot cycle until msg_done
msg_done  output  1  one-cycle pulse when the last stop bit of a message ends

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, port reset.
- Reset values: tx=1, busy=0, msg_done=0, last-sent snapshot={0,0,0,0}, pending=0, FSM=IDLE.
- Change detect: change = {score,stage,life,gameover} != last-sent snapshot, evaluated every cycle.
  - After reset, a nonzero live value therefore triggers a message immediately.
- Trigger: in IDLE, (change | send_req | pending) starts a message.
  - Live inputs are latched into the working snapshot and the last-sent snapshot in that cycle. busy=1 from the next cycle. pending is cleared.
  - A send_req or change while busy sets pending. One more message follows immediately after msg_done, using the values live at that later trigger. Triggers are never queued deeper than one.
- FSM states: IDLE -> CONV -> LOAD -> SHIFT -> (LOAD | DONE) -> IDLE.
- CONV: clamp the score to 999, then sequentially subtract 100, then 10, one subtraction per cycle.
  - Yields hundreds, tens and ones digits in at most 20 cycles.
  - No divider or multiplier is used.
- LOAD: select byte k (k=0..12) of the message, set the shift register, go to SHIFT.
  - LOAD takes no bit time: the start bit of byte k+1 follows the stop bit of byte k with zero idle gap.
- Message bytes, in order:
  - 'S'
  - stage as hex: 0-9 -> 0x30-0x39, 10-15 -> 'A'-'F'
  - ' '
  - 'L'
  - 0x30+life
  - ' '
  - 'P'
  - hundreds, tens, ones as ASCII digits
  - gameover ? 'X' : '-'
  - 0x0D
  - 0x0A
- SHIFT: start bit (0), 8 data bits LSB first, stop bit (1). Each bit is exactly CLKS_PER_BIT cycles, counted by a bit-period counter and a 4-bit bit index.
- Timing:
  - First tx falling edge is no more than 24 cycles after the trigger cycle.
  - One message lasts exactly 130*CLKS_PER_BIT cycles from the first falling edge.
- DONE: msg_done=1 for one cycle, busy=0 in the same cycle, tx=1; return to IDLE.
  - A pending trigger is accepted on the following cycle.
- Simultaneous events: send_req in the same cycle as a change produces one message. A change that reverts before IDLE still sends if pending was set.
- Reset mid-message: tx=1 on the next cycle, the message is aborted, and the snapshot is zeroed. No partial byte is completed.
- Snapshot values are stable for the whole message; input changes during SHIFT never alter bytes in flight.

Test Plan:
- CLKS_PER_BIT=4; after reset hold score=0, stage=0, life=0, gameover=0 for 2000 cycles -> tx stays 1, busy stays 0, no msg_done.
- Set score=123, stage=3, life=5 -> exactly one line "S3 L5 P123-\r\n" (53 33 20 4C 35 20 50 31 32 33 2D 0D 0A). Each bit is 4 cycles, 520 cycles from first falling edge to msg_done.
- Set score=1000, stage=12, life=0, gameover=1 -> "SC L0 P999X\r\n".
- During message 1, change life 5->4, then 4->3 -> exactly one extra message with life '3', starting 1 cycle after the first msg_done. busy is low for that 1 cycle only.
- send_req with unchanged inputs while idle -> identical line resent. send_req during a message -> exactly one follow-up message.
- Assert reset in the middle of byte 6 -> tx=1 next cycle, busy=0, no msg_done. After release, with nonzero inputs, a new full message starts within 24 cycles.
